// File: rtl/marie_pkg.sv
// Shared definitions for the MARIE accumulator core: opcodes, ALU selects,
// skip conditions, the control state enum and the combinational ALU.
package marie_pkg;

   localparam int unsigned WORD_WIDTH = 16;
   localparam int unsigned OP_WIDTH   = 4;

   localparam logic [OP_WIDTH-1:0] OP_LOAD     = 4'h1;
   localparam logic [OP_WIDTH-1:0] OP_STORE    = 4'h2;
   localparam logic [OP_WIDTH-1:0] OP_ADD      = 4'h3;
   localparam logic [OP_WIDTH-1:0] OP_SUBT     = 4'h4;
   localparam logic [OP_WIDTH-1:0] OP_HALT     = 4'h7;
   localparam logic [OP_WIDTH-1:0] OP_SKIPCOND = 4'h8;
   localparam logic [OP_WIDTH-1:0] OP_JUMP     = 4'h9;
   localparam logic [OP_WIDTH-1:0] OP_CLEAR    = 4'hA;

   localparam logic [1:0] ALU_AND = 2'd0;
   localparam logic [1:0] ALU_ADD = 2'd1;
   localparam logic [1:0] ALU_SUB = 2'd2;
   localparam logic [1:0] ALU_OR  = 2'd3;

   // SKIPCOND condition field, taken from IR[11:10]
   localparam logic [1:0] SKIP_NEG   = 2'b00;
   localparam logic [1:0] SKIP_ZERO  = 2'b01;
   localparam logic [1:0] SKIP_POS   = 2'b10;
   localparam logic [1:0] SKIP_NEVER = 2'b11;

   typedef enum logic [3:0] {
      IDLE,
      FETCH1,
      FETCH2,
      FETCH3,
      EXEC_ADDR,
      EXEC_READ,
      EXEC_OP,
      EXEC_WRITE,
      HALT
   } state_t;

   function automatic logic [WORD_WIDTH-1:0] alu(
      input logic [WORD_WIDTH-1:0] a,
      input logic [WORD_WIDTH-1:0] b,
      input logic [1:0]            sel
   );
      logic [WORD_WIDTH-1:0] y;
      case (sel)
         ALU_AND: y = a & b;
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_OR:  y = a | b;
         default: y = '0;
      endcase
      return y;
   endfunction

   // Signed comparison of the accumulator against zero
   function automatic logic skip_taken(
      input logic [1:0]            cond,
      input logic [WORD_WIDTH-1:0] acc
   );
      logic taken;
      case (cond)
         SKIP_NEG:   taken = acc[WORD_WIDTH-1];
         SKIP_ZERO:  taken = (acc == '0);
         SKIP_POS:   taken = !acc[WORD_WIDTH-1] && (acc != '0);
         SKIP_NEVER: taken = 1'b0;
         default:    taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/single_port_sync_ram_large.sv
// Single-port RAM with synchronous read; a read returns data the cycle after
// the address is presented, and the output holds while cs is low or on writes.
module single_port_sync_ram_large #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  cs,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (cs) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/marie_accum_cpu.sv
// MARIE-style 16-bit accumulator core: fetch/execute control around a single
// RAM port that is shared with a host loader while the core is idle or halted.
module marie_accum_cpu
   import marie_pkg::*;
#(
   parameter int unsigned         ADDR_WIDTH = 14,
   parameter int unsigned         DATA_WIDTH = 16,
   parameter logic [DATA_WIDTH-1:0] START_PC = 'h100
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  ld_en,
   input  logic                  ld_we,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_wdata,
   output logic [DATA_WIDTH-1:0] ld_rdata,
   output logic                  halted,
   output logic [DATA_WIDTH-1:0] pc,
   output logic [DATA_WIDTH-1:0] ac
);

   state_t                state;
   logic [DATA_WIDTH-1:0] ir;
   logic [DATA_WIDTH-1:0] mbr;
   logic [DATA_WIDTH-1:0] rdata_hold;
   logic                  host_rd;

   logic                  ram_cs_c;
   logic                  ram_we_c;
   logic [ADDR_WIDTH-1:0] ram_addr_c;
   logic [DATA_WIDTH-1:0] ram_wdata_c;
   logic [DATA_WIDTH-1:0] ram_rdata;

   logic [OP_WIDTH-1:0]   opcode_c;
   logic [ADDR_WIDTH-1:0] operand_c;

   assign opcode_c  = ir[DATA_WIDTH-1 -: OP_WIDTH];
   assign operand_c = ADDR_WIDTH'(ir[11:0]);

   // Host read data is live for the cycle after the read, then held
   assign ld_rdata = host_rd ? ram_rdata : rdata_hold;

   // RAM port steering; writes are blocked while rst is asserted
   always_comb begin
      ram_cs_c    = 1'b0;
      ram_we_c    = 1'b0;
      ram_addr_c  = ld_addr;
      ram_wdata_c = ld_wdata;
      case (state)
         IDLE, HALT: begin
            ram_cs_c = ld_en;
            ram_we_c = ld_en && ld_we && !rst;
         end
         FETCH1: begin
            ram_cs_c   = 1'b1;
            ram_addr_c = pc[ADDR_WIDTH-1:0];
         end
         EXEC_ADDR: begin
            ram_cs_c   = (opcode_c != OP_STORE);
            ram_addr_c = operand_c;
         end
         EXEC_WRITE: begin
            ram_cs_c    = 1'b1;
            ram_we_c    = !rst;
            ram_addr_c  = operand_c;
            ram_wdata_c = mbr;
         end
         default: ;
      endcase
   end

   single_port_sync_ram_large #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk   (clk),
      .cs    (ram_cs_c),
      .we    (ram_we_c),
      .addr  (ram_addr_c),
      .wdata (ram_wdata_c),
      .rdata (ram_rdata)
   );

   // Control sequencer and architectural registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= START_PC;
         ac         <= '0;
         ir         <= '0;
         mbr        <= '0;
         halted     <= 1'b0;
         host_rd    <= 1'b0;
         rdata_hold <= '0;
      end else begin
         host_rd <= 1'b0;
         if (host_rd) begin
            rdata_hold <= ram_rdata;
         end
         case (state)
            IDLE: begin
               // A host access in the same cycle wins over start
               if (ld_en) begin
                  host_rd <= !ld_we;
               end else if (start) begin
                  state <= FETCH1;
               end
            end
            HALT: begin
               if (ld_en) begin
                  host_rd <= !ld_we;
               end
            end
            FETCH1: state <= FETCH2;
            FETCH2: begin
               ir    <= ram_rdata;
               state <= FETCH3;
            end
            FETCH3: begin
               pc <= pc + DATA_WIDTH'(1);
               case (opcode_c)
                  OP_LOAD, OP_STORE, OP_ADD, OP_SUBT: state <= EXEC_ADDR;
                  default:                            state <= EXEC_OP;
               endcase
            end
            EXEC_ADDR: begin
               if (opcode_c == OP_STORE) begin
                  mbr   <= ac;
                  state <= EXEC_WRITE;
               end else begin
                  state <= EXEC_READ;
               end
            end
            EXEC_READ: begin
               mbr   <= ram_rdata;
               state <= EXEC_OP;
            end
            EXEC_OP: begin
               state <= FETCH1;
               case (opcode_c)
                  OP_LOAD:  ac <= mbr;
                  OP_ADD:   ac <= alu(ac, mbr, ALU_ADD);
                  OP_SUBT:  ac <= alu(ac, mbr, ALU_SUB);
                  OP_HALT: begin
                     pc     <= pc - DATA_WIDTH'(1);
                     halted <= 1'b1;
                     state  <= HALT;
                  end
                  OP_SKIPCOND: begin
                     if (skip_taken(ir[11:10], ac)) begin
                        pc <= pc + DATA_WIDTH'(1);
                     end
                  end
                  OP_JUMP:  pc <= DATA_WIDTH'(ir[11:0]);
                  OP_CLEAR: ac <= '0;
                  default: ;
               endcase
            end
            EXEC_WRITE: state <= FETCH1;
            default:    state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_marie_accum_cpu.sv
// Self-checking bench for marie_accum_cpu: directed programs plus random
// straight-line programs compared against an instruction-level model.
module tb_marie_accum_cpu;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        ld_en = 1'b0;
   logic        ld_we = 1'b0;
   logic [13:0] ld_addr = '0;
   logic [15:0] ld_wdata = '0;
   logic [15:0] ld_rdata;
   logic        halted;
   logic [15:0] pc;
   logic [15:0] ac;

   int errors = 0;
   int checks = 0;

   logic [15:0] mm [0:16383];
   logic [15:0] prog [$];

   always #5 clk = ~clk;

   marie_accum_cpu dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .ld_en    (ld_en),
      .ld_we    (ld_we),
      .ld_addr  (ld_addr),
      .ld_wdata (ld_wdata),
      .ld_rdata (ld_rdata),
      .halted   (halted),
      .pc       (pc),
      .ac       (ac)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic host_write(input logic [13:0] a, input logic [15:0] d);
      ld_en = 1'b1; ld_we = 1'b1; ld_addr = a; ld_wdata = d;
      tick();
      ld_en = 1'b0; ld_we = 1'b0;
      mm[a] = d;
   endtask

   task automatic host_read(input logic [13:0] a, output logic [15:0] d);
      ld_en = 1'b1; ld_we = 1'b0; ld_addr = a;
      tick();
      ld_en = 1'b0;
      d = ld_rdata;
   endtask

   task automatic load_prog();
      foreach (prog[i]) host_write(14'h100 + 14'(i), prog[i]);
   endtask

   task automatic run_to_halt(input string name);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5000 && !halted; i++) tick();
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL %s halt_timeout: halted=%0b required 1", name, halted);
      end
   endtask

   // Instruction-level interpreter over the bench memory image
   task automatic model_run(output logic [15:0] m_pc, output logic [15:0] m_ac);
      logic [15:0] p, a, w;
      logic [13:0] x;
      logic        done;
      p = 16'h100; a = '0; done = 1'b0;
      for (int s = 0; s < 4000 && !done; s++) begin
         w = mm[p[13:0]];
         x = {2'b00, w[11:0]};
         p = p + 16'd1;
         case (w[15:12])
            4'h1: a = mm[x];
            4'h2: mm[x] = a;
            4'h3: a = a + mm[x];
            4'h4: a = a - mm[x];
            4'h7: begin p = p - 16'd1; done = 1'b1; end
            4'h8: begin
               if ((w[11:10] == 2'b00 && $signed(a) < 0) ||
                   (w[11:10] == 2'b01 && a == 16'd0) ||
                   (w[11:10] == 2'b10 && $signed(a) > 0)) p = p + 16'd1;
            end
            4'h9: p = {4'h0, w[11:0]};
            4'hA: a = '0;
            default: ;
         endcase
      end
      m_pc = p; m_ac = a;
   endtask

   task automatic test_reset();
      ld_en = 1'b0; start = 1'b0;
      do_reset();
      checks++; if (pc !== 16'h0100) begin errors++; $display("FAIL reset_pc: got %h want 0100", pc); end
      checks++; if (ac !== 16'h0000) begin errors++; $display("FAIL reset_ac: got %h want 0000", ac); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
      checks++; if (ld_rdata !== 16'h0000) begin errors++; $display("FAIL reset_ld_rdata: got %h want 0000", ld_rdata); end
   endtask

   task automatic test_host_rw();
      logic [15:0] d;
      host_write(14'h3FFF, 16'hBEEF);
      host_write(14'h0000, 16'h1234);
      host_read(14'h3FFF, d);
      checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL host_read_3fff: got %h want BEEF", d); end
      tick();
      checks++; if (ld_rdata !== 16'hBEEF) begin errors++; $display("FAIL host_read_hold: got %h want BEEF", ld_rdata); end
      host_read(14'h0000, d);
      checks++; if (d !== 16'h1234) begin errors++; $display("FAIL host_read_0000: got %h want 1234", d); end
   endtask

   task automatic load_multiply();
      prog = '{16'h110C, 16'h210E, 16'h110D, 16'h310B, 16'h210D, 16'h110E, 16'h310F, 16'h210E,
               16'h8400, 16'h9102, 16'h7000, 16'h0005, 16'h0007, 16'h0000, 16'h0000, 16'hFFFF};
      load_prog();
   endtask

   task automatic test_multiply();
      logic [15:0] d, mp, ma;
      do_reset();
      load_multiply();
      run_to_halt("multiply");
      checks++; if (pc !== 16'h010A) begin errors++; $display("FAIL mul_pc: got %h want 010A", pc); end
      checks++; if (ac !== 16'h0000) begin errors++; $display("FAIL mul_ac: got %h want 0000", ac); end
      host_read(14'h010D, d);
      checks++; if (d !== 16'h0023) begin errors++; $display("FAIL mul_product: got %h want 0023", d); end
      host_read(14'h010E, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL mul_counter: got %h want 0000", d); end
      start = 1'b1; tick(); start = 1'b0;
      repeat (5) tick();
      checks++; if (halted !== 1'b1 || pc !== 16'h010A) begin
         errors++; $display("FAIL halt_ignores_start: halted=%b pc=%h want 1/010A", halted, pc);
      end
      model_run(mp, ma);
   endtask

   task automatic test_skipcond();
      logic [15:0] sp [5][4];
      logic [15:0] sd [5];
      logic [15:0] se [5];
      sp = '{'{16'h1200, 16'h8000, 16'hA000, 16'h7000},
             '{16'h1200, 16'h8800, 16'hA000, 16'h7000},
             '{16'hA000, 16'h8400, 16'h1200, 16'h7000},
             '{16'h1200, 16'h8800, 16'hA000, 16'h7000},
             '{16'h1200, 16'h8C00, 16'hA000, 16'h7000}};
      sd = '{16'h8000, 16'h8000, 16'h8000, 16'h0001, 16'h0005};
      se = '{16'h8000, 16'h0000, 16'h0000, 16'h0001, 16'h0000};
      for (int k = 0; k < 5; k++) begin
         do_reset();
         host_write(14'h0200, sd[k]);
         prog.delete();
         for (int j = 0; j < 4; j++) prog.push_back(sp[k][j]);
         load_prog();
         run_to_halt("skipcond");
         checks++; if (ac !== se[k]) begin errors++; $display("FAIL skip_ac case%0d: got %h want %h", k, ac, se[k]); end
         checks++; if (pc !== 16'h0103) begin errors++; $display("FAIL skip_pc case%0d: got %h want 0103", k, pc); end
      end
   endtask

   task automatic test_alu();
      logic [15:0] a_v [3];
      logic [15:0] b_v [3];
      logic [15:0] op_w [3];
      logic [15:0] exp_ac [3];
      a_v = '{16'hFFFF, 16'h0003, 16'hFFFE};
      b_v = '{16'h0001, 16'h0005, 16'h0000};
      op_w = '{16'h3201, 16'h4201, 16'hA000};
      exp_ac = '{16'h0000, 16'hFFFE, 16'h0000};
      for (int k = 0; k < 3; k++) begin
         do_reset();
         host_write(14'h0200, a_v[k]);
         host_write(14'h0201, b_v[k]);
         prog = '{16'h1200, op_w[k], 16'h7000};
         load_prog();
         run_to_halt("alu");
         checks++; if (ac !== exp_ac[k]) begin errors++; $display("FAIL alu_ac case%0d: got %h want %h", k, ac, exp_ac[k]); end
         checks++; if (pc !== 16'h0102) begin errors++; $display("FAIL alu_pc case%0d: got %h want 0102", k, pc); end
      end
   endtask

   task automatic test_random();
      logic [15:0] w, d, mp, ma;
      logic [3:0]  op;
      for (int it = 0; it < 5; it++) begin
         do_reset();
         for (int j = 0; j < 16; j++) host_write(14'h0200 + 14'(j), 16'($urandom));
         prog.delete();
         for (int j = 0; j < 16; j++) begin
            case ($urandom_range(0, 7))
               0: op = 4'h1;
               1: op = 4'h2;
               2: op = 4'h3;
               3: op = 4'h4;
               4: op = 4'h8;
               5: op = 4'hA;
               6: op = 4'h0;
               default: op = 4'h5;
            endcase
            if (op inside {4'h1, 4'h2, 4'h3, 4'h4})
               w = {op, 8'h20, 4'($urandom_range(0, 15))};
            else
               w = {op, 12'($urandom)};
            prog.push_back(w);
         end
         prog.push_back(16'h7000);
         prog.push_back(16'h7000);
         load_prog();
         model_run(mp, ma);
         run_to_halt("random");
         checks++; if (ac !== ma) begin errors++; $display("FAIL rand_ac it%0d: got %h want %h", it, ac, ma); end
         checks++; if (pc !== mp) begin errors++; $display("FAIL rand_pc it%0d: got %h want %h", it, pc, mp); end
         for (int j = 0; j < 16; j++) begin
            host_read(14'h0200 + 14'(j), d);
            checks++;
            if (d !== mm[14'h0200 + 14'(j)]) begin
               errors++; $display("FAIL rand_mem it%0d addr %h: got %h want %h", it, 16'h0200 + 16'(j), d, mm[14'h0200 + 14'(j)]);
            end
         end
      end
   endtask

   task automatic test_run_interference();
      logic [15:0] d, mp, ma;
      do_reset();
      host_write(14'h0300, 16'h1234);
      host_read(14'h0300, d);
      load_multiply();
      start = 1'b1; tick(); start = 1'b0;
      repeat (20) tick();
      ld_en = 1'b1; ld_we = 1'b1; ld_addr = 14'h0300; ld_wdata = 16'hDEAD; start = 1'b1;
      tick();
      ld_addr = 14'h010B; ld_wdata = 16'h0000; start = 1'b0;
      repeat (3) tick();
      ld_we = 1'b0; ld_addr = 14'h0300;
      repeat (3) tick();
      ld_en = 1'b0;
      checks++; if (ld_rdata !== 16'h1234) begin errors++; $display("FAIL run_rdata_hold: got %h want 1234", ld_rdata); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL run_halted_early: got %b want 0", halted); end
      for (int i = 0; i < 5000 && !halted; i++) tick();
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL run_halt_timeout: got %b want 1", halted); end
      checks++; if (pc !== 16'h010A) begin errors++; $display("FAIL run_pc: got %h want 010A", pc); end
      host_read(14'h010D, d);
      checks++; if (d !== 16'h0023) begin errors++; $display("FAIL run_product: got %h want 0023", d); end
      host_read(14'h0300, d);
      checks++; if (d !== 16'h1234) begin errors++; $display("FAIL run_ignored_write: got %h want 1234", d); end
      model_run(mp, ma);
   endtask

   task automatic test_reset_mid_add();
      do_reset();
      host_write(14'h0200, 16'h0007);
      host_write(14'h0201, 16'h0005);
      prog = '{16'h1200, 16'h3201, 16'h7000};
      load_prog();
      start = 1'b1; tick(); start = 1'b0;
      repeat (9) tick();
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL midadd_not_halted: got %b want 0", halted); end
      do_reset();
      checks++; if (pc !== 16'h0100) begin errors++; $display("FAIL midadd_pc: got %h want 0100", pc); end
      checks++; if (ac !== 16'h0000) begin errors++; $display("FAIL midadd_ac: got %h want 0000", ac); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL midadd_halted: got %b want 0", halted); end
      run_to_halt("restart");
      checks++; if (ac !== 16'h000C) begin errors++; $display("FAIL restart_ac: got %h want 000C", ac); end
      checks++; if (pc !== 16'h0102) begin errors++; $display("FAIL restart_pc: got %h want 0102", pc); end
   endtask

   initial begin
      test_reset();
      test_host_rw();
      test_multiply();
      test_skipcond();
      test_alu();
      test_random();
      test_run_interference();
      test_reset_mid_add();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
